// File: rtl/frame_chk.sv
// Receive-side frame checker: validates start, data, optional parity and stop bits of a serial frame.
// Results appear as registered one-cycle pulses on the edge after the deciding sample.
module frame_chk #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_det,
  input  logic                  sample_vld,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  busy,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] p_data
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  bad_q, bad_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  busy_q, busy_d;
  logic                  strt_glitch_q, strt_glitch_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  data_valid_q, data_valid_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    p_data_d      = p_data_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    bad_d         = bad_q;
    stop_cnt_d    = stop_cnt_q;
    strt_glitch_d = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    data_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_det) begin
          state_d    = START;
          par_en_d   = par_en;
          par_typ_d  = par_typ;
          bad_d      = 1'b0;
          stop_cnt_d = 1'b0;
        end
      end
      START: begin
        if (sample_vld) begin
          if (sampled_bit) begin
            state_d       = IDLE;
            strt_glitch_d = 1'b1;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
      end
      DATA: begin
        if (sample_vld) begin
          // Shift in at the top so the first received bit lands in bit 0.
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (sample_vld) begin
          state_d = STOP;
          if (sampled_bit != (^shift_q ^ par_typ_q)) begin
            par_err_d = 1'b1;
            bad_d     = 1'b1;
          end
        end
      end
      STOP: begin
        if (sample_vld) begin
          if (!sampled_bit) begin
            state_d   = IDLE;
            stp_err_d = 1'b1;
          end else if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            state_d = IDLE;
            if (!bad_q) begin
              data_valid_d = 1'b1;
              p_data_d     = shift_q;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      p_data_q      <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      bad_q         <= 1'b0;
      stop_cnt_q    <= 1'b0;
      busy_q        <= 1'b0;
      strt_glitch_q <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      p_data_q      <= p_data_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      bad_q         <= bad_d;
      stop_cnt_q    <= stop_cnt_d;
      busy_q        <= busy_d;
      strt_glitch_q <= strt_glitch_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign busy        = busy_q;
  assign strt_glitch = strt_glitch_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign data_valid  = data_valid_q;
  assign p_data      = p_data_q;

endmodule

// File: tb/tb_frame_chk.sv
// Bench for frame_chk: one instance with one stop bit, one with two, sharing the sample stream.
module tb_frame_chk;

  localparam logic [3:0] GL = 4'b1000;
  localparam logic [3:0] PE = 4'b0100;
  localparam logic [3:0] SE = 4'b0010;
  localparam logic [3:0] DV = 4'b0001;

  typedef struct {
    logic [3:0] vec;
    logic [7:0] pd;
    int         cyc;
  } exp_t;

  logic       CLK, RST;
  logic       start_det1, start_det2, sample_vld, sampled_bit, par_en, par_typ;
  logic       busy1, strt_glitch1, par_err1, stp_err1, data_valid1;
  logic       busy2, strt_glitch2, par_err2, stp_err2, data_valid2;
  logic [7:0] p_data1, p_data2;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  frame_chk #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .start_det(start_det1), .sample_vld(sample_vld),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ),
    .busy(busy1), .strt_glitch(strt_glitch1), .par_err(par_err1),
    .stp_err(stp_err1), .data_valid(data_valid1), .p_data(p_data1)
  );

  frame_chk #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .start_det(start_det2), .sample_vld(sample_vld),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ),
    .busy(busy2), .strt_glitch(strt_glitch2), .par_err(par_err2),
    .stp_err(stp_err2), .data_valid(data_valid2), .p_data(p_data2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: any result pulse must match the next expected entry, including its cycle.
  always @(negedge CLK) begin
    logic [3:0] v1, v2;
    exp_t e;
    v1 = {strt_glitch1, par_err1, stp_err1, data_valid1};
    v2 = {strt_glitch2, par_err2, stp_err2, data_valid2};
    if (v1 != 4'b0000) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL dut1_unexpected_pulse cyc=%0d got=%b p_data=%h expected none", cyc, v1, p_data1);
      end else begin
        e = q1.pop_front();
        if (v1 !== e.vec || p_data1 !== e.pd || cyc != e.cyc) begin
          failures++;
          $display("FAIL dut1_result got pulses=%b p_data=%h cyc=%0d expected pulses=%b p_data=%h cyc=%0d",
                   v1, p_data1, cyc, e.vec, e.pd, e.cyc);
        end
      end
    end
    if (v2 != 4'b0000) begin
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("FAIL dut2_unexpected_pulse cyc=%0d got=%b p_data=%h expected none", cyc, v2, p_data2);
      end else begin
        e = q2.pop_front();
        if (v2 !== e.vec || p_data2 !== e.pd || cyc != e.cyc) begin
          failures++;
          $display("FAIL dut2_result got pulses=%b p_data=%h cyc=%0d expected pulses=%b p_data=%h cyc=%0d",
                   v2, p_data2, cyc, e.vec, e.pd, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // All drive tasks start and end 1ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic samp(input logic b);
    sample_vld  = 1'b1;
    sampled_bit = b;
    @(posedge CLK);
    #1;
    sample_vld  = 1'b0;
  endtask

  task automatic start(input int which, input logic pe, input logic pt);
    par_en  = pe;
    par_typ = pt;
    if (which == 1) start_det1 = 1'b1;
    else            start_det2 = 1'b1;
    @(posedge CLK);
    #1;
    start_det1 = 1'b0;
    start_det2 = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    for (int i = 0; i < 8; i++) begin
      samp(d[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic push(input int which, input logic [3:0] vec, input logic [7:0] pd);
    exp_t e;
    e.vec = vec;
    e.pd  = pd;
    e.cyc = cyc;
    if (which == 1) q1.push_back(e);
    else            q2.push_back(e);
  endtask

  initial begin
    RST = 1'b0;
    start_det1 = 1'b0; start_det2 = 1'b0;
    sample_vld = 1'b0; sampled_bit = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    idle(3);
    chk("reset_busy1", busy1, 0);
    chk("reset_pulses1", {strt_glitch1, par_err1, stp_err1, data_valid1}, 0);
    chk("reset_p_data1", p_data1, 0);
    chk("reset_busy2", busy2, 0);
    chk("reset_p_data2", p_data2, 0);
    RST = 1'b1;
    idle(1);

    // 8N1 0xA5, with a sample strobe coincident with start_det and gaps between bits
    sample_vld = 1'b1; sampled_bit = 1'b1;
    start(1, 1'b0, 1'b0);
    sample_vld = 1'b0;
    chk("a5_busy_after_start", busy1, 1);
    idle(2);
    chk("a5_busy_held_no_sample", busy1, 1);
    samp(1'b0);
    send_byte(8'hA5, 1);
    samp(1'b1);
    push(1, DV, 8'hA5);
    chk("a5_busy_end", busy1, 0);
    idle(2);

    // start glitch
    start(1, 1'b0, 1'b0);
    samp(1'b1);
    push(1, GL, 8'hA5);
    chk("glitch_busy", busy1, 0);
    idle(2);

    // even parity, data 0x03 expects parity 0, sample 1 -> par_err and no data_valid
    start(1, 1'b1, 1'b0);
    samp(1'b0);
    send_byte(8'h03, 0);
    samp(1'b1);
    push(1, PE, 8'hA5);
    chk("even_busy_after_par", busy1, 1);
    samp(1'b1);
    chk("even_busy_end", busy1, 0);
    chk("even_p_data_kept", p_data1, 8'hA5);
    idle(2);

    // odd parity, data 0x03 expects parity 1; start_det mid-frame must be ignored
    start(1, 1'b1, 1'b1);
    samp(1'b0);
    samp(1'b1);
    start_det1 = 1'b1;
    samp(1'b1);
    start_det1 = 1'b0;
    for (int i = 0; i < 6; i++) samp(1'b0);
    samp(1'b1);
    samp(1'b1);
    push(1, DV, 8'h03);
    // back-to-back: start accepted in the cycle data_valid is high
    start(1, 1'b1, 1'b0);
    chk("b2b_busy", busy1, 1);
    samp(1'b0);
    send_byte(8'h03, 0);
    samp(1'b1);
    push(1, PE, 8'h03);
    idle(1);
    samp(1'b0);
    push(1, SE, 8'h03);
    chk("parstop_busy_end", busy1, 0);
    idle(2);

    // two stop bits: second stop low -> stp_err; then both high -> 0x5A
    start(2, 1'b0, 1'b0);
    samp(1'b0);
    send_byte(8'h5A, 0);
    samp(1'b1);
    chk("two_stop_busy_mid", busy2, 1);
    samp(1'b0);
    push(2, SE, 8'h00);
    chk("two_stop_err_busy", busy2, 0);
    idle(1);
    start(2, 1'b0, 1'b0);
    samp(1'b0);
    send_byte(8'h5A, 0);
    samp(1'b1);
    idle(1);
    samp(1'b1);
    push(2, DV, 8'h5A);
    chk("dut1_idle_during_dut2", busy1, 0);
    idle(2);

    // reset mid-frame after four data bits, then a full 0x3C frame
    start(1, 1'b0, 1'b0);
    samp(1'b0);
    samp(1'b0); samp(1'b1); samp(1'b0); samp(1'b1);
    RST = 1'b0;
    idle(2);
    chk("midrst_busy", busy1, 0);
    chk("midrst_p_data1", p_data1, 0);
    chk("midrst_p_data2", p_data2, 0);
    RST = 1'b1;
    idle(2);
    start(1, 1'b0, 1'b0);
    samp(1'b0);
    send_byte(8'h3C, 0);
    samp(1'b1);
    push(1, DV, 8'h3C);
    idle(4);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_chk.md
FRAME_CHK -- requirements
Module: frame_chk

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, number of stop bits checked per frame; legal values 1 or 2.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-low.
REQ-005 start_det  input  1  one-cycle pulse from edge detector: falling edge seen on RX line.
REQ-006 sample_vld  input  1  one-cycle strobe: sampled_bit holds a valid mid-bit sample.
REQ-007 sampled_bit  input  1  sampled RX bit value.
REQ-008 par_en  input  1  1 = frame carries a parity bit.
REQ-009 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-010 busy  output  1  high while state is not IDLE.
REQ-011 strt_glitch  output  1  one-cycle pulse: start sample read high.
REQ-012 par_err  output  1  one-cycle pulse: parity mismatch.
REQ-013 stp_err  output  1  one-cycle pulse: stop sample read low.
REQ-014 data_valid  output  1  one-cycle pulse: error-free frame received.
REQ-015 p_data  output  DATA_WIDTH  last error-free frame data, LSB = first data bit received.

Function
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: start_det -> START; par_en and par_typ latched same edge; sample_vld ignored, including when simultaneous with start_det.
REQ-018 start_det outside IDLE SHALL be ignored.
REQ-019 START, sample_vld with sampled_bit=0 -> DATA, bit counter cleared.
REQ-020 START, sample_vld with sampled_bit=1 -> IDLE, strt_glitch high next cycle for exactly one cycle.
REQ-021 DATA: each sample_vld shifts sampled_bit into internal shift register LSB-first (first bit ends in bit 0), counter increments.
REQ-022 DATA: on the DATA_WIDTH-th sample -> PARITY if latched par_en=1, else STOP.
REQ-023 Expected parity bit = XOR of all data bits XOR latched par_typ.
REQ-024 PARITY, sample_vld: mismatch -> par_err pulse next cycle and frame flagged bad; -> STOP in both cases.
REQ-025 STOP: each sample_vld with sampled_bit=1 counts one stop bit; after STOP_BITS good stop bits -> IDLE.
REQ-026 STOP, sample_vld with sampled_bit=0 -> IDLE immediately, stp_err pulse next cycle, remaining stop bits not checked.
REQ-027 Frame end, stop bits good, no parity error: p_data loaded from shift register, data_valid pulses one cycle, both on the edge after the final stop sample.
REQ-028 Any error: p_data SHALL hold its previous value and data_valid SHALL stay low.
REQ-029 Cycles without sample_vld SHALL not change state, counters or shift register; no timeout.
REQ-030 All outputs registered; at most one of strt_glitch/par_err/stp_err/data_valid high in any cycle.
REQ-031 Parity error with stop failure SHALL pulse par_err and stp_err in separate cycles.
REQ-032 New start_det is accepted on the first cycle back in IDLE, including the cycle a result pulse is high.

Reset
REQ-033 RST=0 at a clock edge: state IDLE; counters, shift register and latched config cleared; busy, strt_glitch, par_err, stp_err, data_valid = 0; p_data = 0.
REQ-034 Reset mid-frame SHALL abort the frame with no error or valid pulse emitted.

Verification
REQ-035 8N1, parity off: start_det, samples 0, data 0xA5 LSB-first (1,0,1,0,0,1,0,1), stop 1 -> data_valid one cycle, p_data=0xA5.
REQ-036 Start glitch: start_det, then sample 1 -> strt_glitch one cycle, busy falls, p_data unchanged.
REQ-037 Even parity on, data 0x03, parity sample 1 -> par_err pulse; after stop 1 no data_valid; p_data unchanged.
REQ-038 Odd parity on, data 0x03, parity 1, stop 1 -> data_valid, p_data=0x03.
REQ-039 STOP_BITS=2, data 0x5A, stops 1 then 0 -> stp_err after second stop sample, no data_valid; repeat with stops 1,1 -> p_data=0x5A.
REQ-040 RST=0 after 4 data bits, then full 0x3C frame -> no pulses during reset, then data_valid with p_data=0x3C.
